acia_rxf: RTL and testbench
===========================

ACIA_RXF -- requirements
Module: acia_rxf

Interface
REQ-001 Parameter DEPTH, 4, FIFO entries; power of two, 2..64.
REQ-002 Parameter IRQ_LEVEL, 1, FIFO fill level at or above which RXIRQ asserts; 1..DEPTH.
REQ-003 Port RESET  in  1  reset, asynchronous, active-low.
REQ-004 Port BCLK  in  1  clock, 16x bit rate; all logic in this domain.
REQ-005 Port RX  in  1  serial input, idle high, pre-synchronised.
REQ-006 Port R_WL  in  2  word length: 00=8, 01=7, 10=6, 11=5 bits.
REQ-007 Port R_PME  in  1  parity bit present.
REQ-008 Port R_PMC  in  2  parity mode: 00 odd, 01 even, 10 mark, 11 space.
REQ-009 Port R_SBN  in  1  two stop bits when 1 and R_PME=0.
REQ-010 Port RXTAKEN  in  1  one-cycle pop strobe for head entry.
REQ-011 Port RXDATA  out  8  head data, right-justified, unused upper bits 0.
REQ-012 Port FRAME, PARITY, BREAK  out  1 each  head-entry error flags.
REQ-013 Port RXVALID  out  1  FIFO not empty.
REQ-014 Port LEVEL  out  $clog2(DEPTH+1)  entries held.
REQ-015 Port OVERFLOW  out  1  sticky: word lost to full FIFO.
REQ-016 Port RXIRQ  out  1  LEVEL>=IRQ_LEVEL or OVERFLOW.

Function
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP, STOP2, BRKWAIT.
REQ-018 IDLE: tick counter=0; RX=0 -> START.
REQ-019 Each bit: counter 0..15; samples at ticks 7, 8, 9; bit value = 2-of-3 majority; bit committed at tick 15.
REQ-020 START: at tick 9 majority 1 -> IDLE (glitch rejected); else latch R_WL/R_PME/R_PMC/R_SBN, continue to tick 15, -> DATA.
REQ-021 Config inputs changing mid-frame shall not affect the current frame.
REQ-022 DATA: LSB first, N bits per latched word length; then PARITY if PME else STOP.
REQ-023 PARITY error: odd/even -> XOR of data and parity bit mismatches mode; mark -> bit 0; space -> bit 1.
REQ-024 STOP tick 15: FRAME = stop bit 0; BREAK = all data bits, parity bit (if any) and stop bit 0; push {BREAK,PARITY,FRAME,DATA}.
REQ-025 After STOP: BREAK -> BRKWAIT; else R_SBN=1 and PME=0 -> STOP2 (16 ticks, not checked); else IDLE.
REQ-026 BRKWAIT: stay until RX majority 1 at tick 9 sample, then IDLE; no further pushes meanwhile.
REQ-027 Push visible on RXVALID/LEVEL/head outputs the cycle after STOP tick 15.
REQ-028 RXTAKEN with RXVALID=1: pop, next entry on outputs next cycle; with RXVALID=0: ignored.
REQ-029 Push while full and no pop: word discarded, FIFO unchanged, OVERFLOW<=1.
REQ-030 Push and pop same cycle: both performed, LEVEL unchanged, no overflow even when full.
REQ-031 OVERFLOW clears on an accepted pop unless same-cycle push overflows.
REQ-032 Head outputs hold 0 when FIFO empty.
REQ-033 Read/write pointers wrap modulo DEPTH.

Reset
REQ-034 RESET low: FSM IDLE, counters 0, FIFO empty, all outputs 0, asynchronously.
REQ-035 Reset mid-frame discards partial word; reception restarts on next falling edge after release.

Structure
REQ-036 Package acia_pkg: FSM state enum, R_WL and R_PMC encodings, FIFO entry field indices.
REQ-037 Sub-module acia_fifo: synchronous DEPTH x 11-bit FIFO with push, pop, full, empty, level.

Verification
REQ-038 8N1, byte 0x55, RX clean -> RXDATA=0x55, FRAME=PARITY=BREAK=0, LEVEL=1.
REQ-039 7E1, 0x41 sent with parity bit 1 -> RXDATA=0x41, PARITY=1; repeat with bit 0 -> PARITY=0.
REQ-040 DEPTH=4, 5 bytes 0x01..0x05, no pops -> LEVEL=4, OVERFLOW=1, pops yield 0x01..0x04, OVERFLOW clears on first pop.
REQ-041 RX low 4 ticks then high -> no push, FSM returns IDLE; single-tick glitch at tick 8 of data bit -> value unchanged.
REQ-042 RX held low 40 bit times, 8N1 -> one entry RXDATA=0x00, BREAK=1, FRAME=1; next byte 0xA5 after release received correctly.
REQ-043 RESET pulse during bit 4 of a frame -> LEVEL=0, all outputs 0; following 0x3C received correctly.

Source files
------------

// File: rtl/acia_pkg.sv
// +--------------------------------------------------------------------+
// | acia_pkg : shared types and field layout for the ACIA receive path  |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package acia_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_STOP2,
    S_BRKWAIT
  } rx_state_t;

  localparam logic [1:0] WL_8 = 2'b00;
  localparam logic [1:0] WL_7 = 2'b01;
  localparam logic [1:0] WL_6 = 2'b10;
  localparam logic [1:0] WL_5 = 2'b11;

  localparam logic [1:0] PMC_ODD   = 2'b00;
  localparam logic [1:0] PMC_EVEN  = 2'b01;
  localparam logic [1:0] PMC_MARK  = 2'b10;
  localparam logic [1:0] PMC_SPACE = 2'b11;

  localparam int ENTRY_W    = 11;
  localparam int F_DATA_LSB = 0;
  localparam int F_DATA_MSB = 7;
  localparam int F_FRAME    = 8;
  localparam int F_PARITY   = 9;
  localparam int F_BREAK    = 10;

  // Word-length code counts down from 8 bits.
  function automatic logic [3:0] word_bits(input logic [1:0] wl);
    return 4'd8 - {2'b00, wl};
  endfunction

endpackage

`default_nettype wire

// File: rtl/acia_fifo.sv
// +--------------------------------------------------------------------+
// | acia_fifo : synchronous DEPTH x WIDTH receive FIFO                  |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module acia_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                         RESET,
  input  logic                         BCLK,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge BCLK) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge BCLK or negedge RESET) begin
    if (!RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/acia_rxf.sv
// +--------------------------------------------------------------------+
// | acia_rxf : ACIA serial receiver with error flags and receive FIFO   |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

import acia_pkg::*;

module acia_rxf #(
  parameter int DEPTH     = 4,
  parameter int IRQ_LEVEL = 1
) (
  input  logic                        RESET,
  input  logic                        BCLK,
  input  logic                        RX,
  input  logic [1:0]                  R_WL,
  input  logic                        R_PME,
  input  logic [1:0]                  R_PMC,
  input  logic                        R_SBN,
  input  logic                        RXTAKEN,
  output logic [7:0]                  RXDATA,
  output logic                        FRAME,
  output logic                        PARITY,
  output logic                        BREAK,
  output logic                        RXVALID,
  output logic [$clog2(DEPTH+1)-1:0]  LEVEL,
  output logic                        OVERFLOW,
  output logic                        RXIRQ
);

  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] IRQ_LV = LW'(IRQ_LEVEL);

  rx_state_t          state;
  logic [3:0]         tick;
  logic               s7;
  logic               s8;
  logic               bit_val;
  logic [2:0]         bit_idx;
  logic [7:0]         data;
  logic               par_bit;
  logic [3:0]         nbits;
  logic               pme_l;
  logic               sbn_l;
  logic [1:0]         pmc_l;
  logic               maj;
  logic               push;
  logic               pop_ok;
  logic               full;
  logic               empty;
  logic               par_err;
  logic               brk;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;

  assign maj  = (s7 & s8) | (s7 & RX) | (s8 & RX);
  assign push = (state == S_STOP) && (tick == 4'd15);

  always_comb begin
    par_err = 1'b0;
    if (pme_l) begin
      case (pmc_l)
        PMC_ODD:  par_err = ~(^data ^ par_bit);
        PMC_EVEN: par_err = ^data ^ par_bit;
        PMC_MARK: par_err = ~par_bit;
        default:  par_err = par_bit;
      endcase
    end
  end

  // bit_val holds the stop bit while in STOP; data upper bits are already 0.
  assign brk   = (data == 8'd0) && !(pme_l && par_bit) && !bit_val;
  assign entry = {brk, par_err, ~bit_val, data};

  always_ff @(posedge BCLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      tick    <= 4'd0;
      s7      <= 1'b1;
      s8      <= 1'b1;
      bit_val <= 1'b1;
      bit_idx <= 3'd0;
      data    <= 8'd0;
      par_bit <= 1'b0;
      nbits   <= 4'd8;
      pme_l   <= 1'b0;
      sbn_l   <= 1'b0;
      pmc_l   <= PMC_ODD;
    end else begin
      tick <= (state == S_IDLE) ? 4'd0 : tick + 4'd1;
      if (state != S_IDLE) begin
        if (tick == 4'd7) s7 <= RX;
        if (tick == 4'd8) s8 <= RX;
        if (tick == 4'd9) bit_val <= maj;
      end
      case (state)
        S_IDLE: begin
          if (!RX) state <= S_START;
        end
        S_START: begin
          if (tick == 4'd9) begin
            if (maj) begin
              state <= S_IDLE;
            end else begin
              nbits   <= word_bits(R_WL);
              pme_l   <= R_PME;
              pmc_l   <= R_PMC;
              sbn_l   <= R_SBN;
              data    <= 8'd0;
              bit_idx <= 3'd0;
            end
          end else if (tick == 4'd15) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick == 4'd15) begin
            data[bit_idx] <= bit_val;
            bit_idx       <= bit_idx + 3'd1;
            if ({1'b0, bit_idx} == nbits - 4'd1)
              state <= pme_l ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (tick == 4'd15) begin
            par_bit <= bit_val;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick == 4'd15) begin
            if (brk)                 state <= S_BRKWAIT;
            else if (sbn_l && !pme_l) state <= S_STOP2;
            else                     state <= S_IDLE;
          end
        end
        S_STOP2: begin
          if (tick == 4'd15) state <= S_IDLE;
        end
        S_BRKWAIT: begin
          if (tick == 4'd9 && maj) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pop_ok = RXTAKEN && !empty;

  acia_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .RESET (RESET),
    .BCLK  (BCLK),
    .push  (push),
    .pop   (RXTAKEN),
    .wdata (entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (LEVEL)
  );

  always_ff @(posedge BCLK or negedge RESET) begin
    if (!RESET)                     OVERFLOW <= 1'b0;
    else if (push && full && !pop_ok) OVERFLOW <= 1'b1;
    else if (pop_ok)                OVERFLOW <= 1'b0;
  end

  assign RXDATA  = head[F_DATA_MSB:F_DATA_LSB];
  assign FRAME   = head[F_FRAME];
  assign PARITY  = head[F_PARITY];
  assign BREAK   = head[F_BREAK];
  assign RXVALID = !empty;
  assign RXIRQ   = (LEVEL >= IRQ_LV) || OVERFLOW;

endmodule

`default_nettype wire

// File: tb/tb_acia_rxf.sv
// +--------------------------------------------------------------------+
// | tb_acia_rxf : directed self-checking bench for acia_rxf             |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_acia_rxf;

  logic       RESET;
  logic       BCLK;
  logic       RX;
  logic [1:0] R_WL;
  logic       R_PME;
  logic [1:0] R_PMC;
  logic       R_SBN;
  logic       RXTAKEN;
  logic [7:0] RXDATA;
  logic       FRAME;
  logic       PARITY;
  logic       BREAK;
  logic       RXVALID;
  logic [2:0] LEVEL;
  logic       OVERFLOW;
  logic       RXIRQ;

  int errors = 0;
  int checks = 0;

  acia_rxf #(
    .DEPTH     (4),
    .IRQ_LEVEL (2)
  ) dut (
    .RESET    (RESET),
    .BCLK     (BCLK),
    .RX       (RX),
    .R_WL     (R_WL),
    .R_PME    (R_PME),
    .R_PMC    (R_PMC),
    .R_SBN    (R_SBN),
    .RXTAKEN  (RXTAKEN),
    .RXDATA   (RXDATA),
    .FRAME    (FRAME),
    .PARITY   (PARITY),
    .BREAK    (BREAK),
    .RXVALID  (RXVALID),
    .LEVEL    (LEVEL),
    .OVERFLOW (OVERFLOW),
    .RXIRQ    (RXIRQ)
  );

  initial BCLK = 1'b0;
  always #5 BCLK = ~BCLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge BCLK);
      #1;
    end
  endtask

  task automatic tx_bit(input logic b);
    RX = b;
    cyc(16);
  endtask

  // Bit with a one-clock inversion landing on the receiver's middle sample.
  task automatic tx_bit_glitch(input logic b);
    RX = b;
    cyc(9);
    RX = ~b;
    cyc(1);
    RX = b;
    cyc(6);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input bit has_par, input logic par);
    tx_bit(1'b0);
    for (int i = 0; i < n; i++) tx_bit(d[i]);
    if (has_par) tx_bit(par);
    tx_bit(1'b1);
    cyc(3);
  endtask

  task automatic pop;
    RXTAKEN = 1'b1;
    cyc(1);
    RXTAKEN = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] wl, input logic pme, input logic [1:0] pmc);
    R_WL  = wl;
    R_PME = pme;
    R_PMC = pmc;
  endtask

  initial begin
    RESET   = 1'b0;
    RX      = 1'b1;
    RXTAKEN = 1'b0;
    R_SBN   = 1'b0;
    cfg(2'b00, 1'b0, 2'b00);
    cyc(3);
    check("rst_valid", RXVALID, 0);
    check("rst_level", LEVEL, 0);
    check("rst_data", RXDATA, 0);
    check("rst_flags", {BREAK, PARITY, FRAME}, 0);
    check("rst_ovf_irq", {OVERFLOW, RXIRQ}, 0);
    RESET = 1'b1;
    cyc(20);

    // 8N1 0x55
    send_frame(8'h55, 8, 1'b0, 1'b0);
    check("8n1_data", RXDATA, 16'h55);
    check("8n1_flags", {BREAK, PARITY, FRAME}, 0);
    check("8n1_level", LEVEL, 1);
    check("8n1_irq_below", RXIRQ, 0);
    pop;
    check("pop_empty_level", LEVEL, 0);
    check("pop_empty_data", RXDATA, 0);

    // 7E1 0x41: correct parity is 0
    cfg(2'b01, 1'b1, 2'b01);
    send_frame(8'h41, 7, 1'b1, 1'b1);
    check("7e1_bad_data", RXDATA, 16'h41);
    check("7e1_bad_par", PARITY, 1);
    pop;
    send_frame(8'h41, 7, 1'b1, 1'b0);
    check("7e1_good_data", RXDATA, 16'h41);
    check("7e1_good_par", PARITY, 0);
    pop;

    // 8-bit mark parity, 0x00 with parity bit 0
    cfg(2'b00, 1'b1, 2'b10);
    send_frame(8'h00, 8, 1'b1, 1'b0);
    check("mark_flags", {BREAK, PARITY, FRAME}, 3'b010);
    pop;

    // 5N1 0x15 with config scrambled after the start bit
    cfg(2'b11, 1'b0, 2'b00);
    tx_bit(1'b0);
    cfg(2'b00, 1'b1, 2'b11);
    tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1);
    tx_bit(1'b1);
    cyc(3);
    check("latch_cfg_data", RXDATA, 16'h15);
    check("latch_cfg_flags", {BREAK, PARITY, FRAME}, 0);
    check("latch_cfg_level", LEVEL, 1);
    pop;

    // Overflow: five frames into a 4-deep FIFO
    cfg(2'b00, 1'b0, 2'b00);
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 8, 1'b0, 1'b0);
      if (k == 2) check("irq_at_level", RXIRQ, 1);
    end
    check("ovf_level", LEVEL, 4);
    check("ovf_flag", OVERFLOW, 1);
    check("ovf_head", RXDATA, 16'h01);
    pop;
    check("ovf_clear", OVERFLOW, 0);
    check("ovf_pop1_data", RXDATA, 16'h02);
    check("ovf_pop1_level", LEVEL, 3);
    pop;
    check("ovf_pop2_data", RXDATA, 16'h03);
    pop;
    check("ovf_pop3_data", RXDATA, 16'h04);
    pop;
    check("ovf_drained", {RXVALID, LEVEL}, 0);
    pop;
    check("pop_when_empty", {RXVALID, LEVEL}, 0);

    // Short start glitch
    RX = 1'b0;
    cyc(4);
    RX = 1'b1;
    cyc(40);
    check("start_glitch_level", LEVEL, 0);

    // Data bit glitch on the middle sample
    tx_bit(1'b0);
    tx_bit(1'b1); tx_bit(1'b0); tx_bit_glitch(1'b1); tx_bit(1'b0);
    tx_bit(1'b0); tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1);
    tx_bit(1'b1);
    cyc(3);
    check("data_glitch_data", RXDATA, 16'hA5);
    check("data_glitch_level", LEVEL, 1);
    pop;

    // Break: 40 bit times low
    RX = 1'b0;
    cyc(640);
    RX = 1'b1;
    cyc(32);
    check("brk_level", LEVEL, 1);
    check("brk_data", RXDATA, 0);
    check("brk_flags", {BREAK, PARITY, FRAME}, 3'b101);
    pop;
    send_frame(8'hA5, 8, 1'b0, 1'b0);
    check("after_brk_data", RXDATA, 16'hA5);
    check("after_brk_flags", {BREAK, PARITY, FRAME}, 0);
    check("after_brk_level", LEVEL, 1);

    // Reset during bit 4, with one entry still held
    tx_bit(1'b0);
    tx_bit(1'b1); tx_bit(1'b1); tx_bit(1'b1); tx_bit(1'b1);
    RX = 1'b0;
    cyc(5);
    RESET = 1'b0;
    #2;
    check("async_rst_level", {RXVALID, LEVEL}, 0);
    check("async_rst_data", RXDATA, 0);
    check("async_rst_misc", {BREAK, PARITY, FRAME, OVERFLOW, RXIRQ}, 0);
    RX = 1'b1;
    cyc(4);
    RESET = 1'b1;
    cyc(40);
    check("post_rst_idle", LEVEL, 0);
    send_frame(8'h3C, 8, 1'b0, 1'b0);
    check("post_rst_data", RXDATA, 16'h3C);
    check("post_rst_level", LEVEL, 1);
    check("post_rst_flags", {BREAK, PARITY, FRAME}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
